// File: rtl/clock_replacement_state_pkg.sv
// cache_repl_pkg: shared types and helpers for the clock replacement state store.
package cache_repl_pkg;
    localparam int MAX_ASSOC = 64;

    typedef enum logic {INIT, IDLE} repl_state_e;

    function automatic logic [MAX_ASSOC-1:0] rotl1_onehot(input logic [MAX_ASSOC-1:0] m, input int unsigned ways);
        logic [MAX_ASSOC-1:0] keep;
        keep = (ways >= MAX_ASSOC) ? '1 : ((MAX_ASSOC'(1) << ways) - MAX_ASSOC'(1));
        return ((m << 1) | (m >> (ways - 1))) & keep;
    endfunction
endpackage

// File: rtl/clock_replacement_state.sv
// clock_replacement_state: per-set clock hand and use bits with registered lookup and forwarded updates.
module clock_replacement_state
    import cache_repl_pkg::*;
#(
    parameter int ASSOCIATIVITY = 2,
    parameter int NUM_SETS      = 16,
    localparam int SET_W        = $clog2(NUM_SETS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    output logic                     o_ready,
    input  logic                     i_lookup_valid,
    input  logic [SET_W-1:0]         i_lookup_set,
    output logic                     o_lookup_valid,
    output logic [ASSOCIATIVITY-1:0] o_clock,
    output logic [ASSOCIATIVITY-1:0] o_clock_use,
    input  logic                     i_hit_valid,
    input  logic [SET_W-1:0]         i_hit_set,
    input  logic [ASSOCIATIVITY-1:0] i_hit_way_mask,
    input  logic                     i_evict_valid,
    input  logic [SET_W-1:0]         i_evict_set,
    input  logic [ASSOCIATIVITY-1:0] i_evict_way_mask,
    input  logic [ASSOCIATIVITY-1:0] i_clock_use_if_evict
);
    typedef struct packed {
        logic [ASSOCIATIVITY-1:0] hand;
        logic [ASSOCIATIVITY-1:0] use_bits;
    } clock_entry_t;

    localparam clock_entry_t INIT_ENTRY = '{hand: ASSOCIATIVITY'(1), use_bits: '0};

    clock_entry_t      mem_q [NUM_SETS];
    repl_state_e       state_q, state_d;
    logic [SET_W-1:0]  cnt_q, cnt_d;
    logic              lk_valid_q;
    clock_entry_t      lk_q;
    logic              hit_we, ev_we, same_set;
    clock_entry_t      hit_entry, ev_entry, lk_entry;

    assign o_ready        = state_q == IDLE;
    assign o_lookup_valid = lk_valid_q;
    assign o_clock        = lk_q.hand;
    assign o_clock_use    = lk_q.use_bits;

    always_comb begin
        state_d = (i_flush || (state_q == INIT && cnt_q != SET_W'(NUM_SETS - 1))) ? INIT : IDLE;
        cnt_d   = (i_flush || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    end

    // The evict entry already folds in a same-set hit, so it alone is written and forwarded.
    always_comb begin
        hit_we             = o_ready && i_hit_valid;
        ev_we              = o_ready && i_evict_valid && (|i_evict_way_mask);
        same_set           = hit_we && (i_hit_set == i_evict_set);
        hit_entry          = mem_q[i_hit_set];
        hit_entry.use_bits = hit_entry.use_bits | i_hit_way_mask;
        ev_entry.hand      = ASSOCIATIVITY'(rotl1_onehot(MAX_ASSOC'(i_evict_way_mask), ASSOCIATIVITY));
        ev_entry.use_bits  = i_clock_use_if_evict | (same_set ? i_hit_way_mask : '0);
        lk_entry           = (ev_we && i_evict_set == i_lookup_set) ? ev_entry :
                             (hit_we && i_hit_set == i_lookup_set) ? hit_entry : mem_q[i_lookup_set];
    end

    always_ff @(posedge i_clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= INIT_ENTRY;
        end else begin
            if (hit_we && !(ev_we && same_set)) mem_q[i_hit_set] <= hit_entry;
            if (ev_we) mem_q[i_evict_set] <= ev_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            lk_valid_q <= 1'b0;
            lk_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lk_valid_q <= o_ready && i_lookup_valid;
            if (o_ready && i_lookup_valid) lk_q <= lk_entry;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_rst && o_ready) begin
            if (i_hit_valid) assert ($onehot(i_hit_way_mask)) else $error("hit way mask not one-hot");
            if (i_evict_valid) assert ($onehot0(i_evict_way_mask)) else $error("evict way mask not one-hot");
        end
    end
`endif
endmodule

// File: tb/tb_clock_replacement_state.sv
// tb_clock_replacement_state: directed plan plus randomized traffic checked against a set-level model.
module tb_clock_replacement_state;
    localparam int A = 4;
    localparam int N = 4;

    logic       clk = 0, rst = 0, flush = 0;
    logic       lk_in = 0, hv = 0, ev = 0;
    logic [1:0] lset = 0, hset = 0, eset = 0;
    logic [3:0] hmask = 0, emask = 0, ifev = 0;
    logic       ready, lvo;
    logic [3:0] oclk, ouse;

    int tests = 0, fails = 0;

    clock_replacement_state #(.ASSOCIATIVITY(A), .NUM_SETS(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .o_ready(ready),
        .i_lookup_valid(lk_in), .i_lookup_set(lset), .o_lookup_valid(lvo),
        .o_clock(oclk), .o_clock_use(ouse),
        .i_hit_valid(hv), .i_hit_set(hset), .i_hit_way_mask(hmask),
        .i_evict_valid(ev), .i_evict_set(eset), .i_evict_way_mask(emask),
        .i_clock_use_if_evict(ifev)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Set-level model: busy counts cycles left until the store accepts requests.
    logic [3:0] hand_m [N];
    logic [3:0] use_m [N];
    int         busy = -1;
    logic       e_ready = 0, e_lv = 0;
    logic [3:0] e_clock = 0, e_use = 0;

    task automatic model_clear();
        for (int s = 0; s < N; s++) begin
            hand_m[s] = 4'b0001;
            use_m[s]  = 4'b0000;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            busy = N;
            model_clear();
            e_lv = 0; e_clock = 0; e_use = 0; e_ready = 0;
        end else if (busy >= 0) begin
            e_lv = 0;
            if (busy == 0) begin
                if (ev && emask != 0) begin
                    use_m[eset]  = ifev;
                    hand_m[eset] = (emask == 4'b1000) ? 4'b0001 : emask * 2;
                end
                if (hv) use_m[hset] = use_m[hset] | hmask;
                if (lk_in) begin
                    e_lv    = 1;
                    e_clock = hand_m[lset];
                    e_use   = use_m[lset];
                end
            end
            if (flush) begin
                busy = N;
                model_clear();
            end else if (busy > 0) busy--;
            e_ready = busy == 0;
        end
    end

    always @(negedge clk) begin
        if (busy >= 0) begin
            check("model_ready", {3'b0, ready}, {3'b0, e_ready});
            check("model_lookup_valid", {3'b0, lvo}, {3'b0, e_lv});
            check("model_clock", oclk, e_clock);
            check("model_use", ouse, e_use);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        lk_in = 0; hv = 0; ev = 0; flush = 0;
    endtask

    initial begin
        rst = 1;
        cyc();
        rst = 0;
        check("reset_ready", {3'b0, ready}, 4'b0000);
        check("reset_lookup_valid", {3'b0, lvo}, 4'b0000);
        check("reset_clock", oclk, 4'b0000);
        check("reset_use", ouse, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            hv = 1; hset = 0; hmask = 4'b0100; lk_in = 1; lset = 0;
            cyc();
            check("init_ready_low", {3'b0, ready}, 4'b0000);
            check("init_lookup_ignored", {3'b0, lvo}, 4'b0000);
        end
        idle();
        cyc();
        check("init_ready_high", {3'b0, ready}, 4'b0001);
        lk_in = 1; lset = 2;
        cyc();
        check("first_lookup_valid", {3'b0, lvo}, 4'b0001);
        check("first_lookup_clock", oclk, 4'b0001);
        check("first_lookup_use", ouse, 4'b0000);
        lset = 0;
        cyc();
        check("ignored_hit_use", ouse, 4'b0000);
        idle(); hv = 1; hset = 1; hmask = 4'b0100;
        cyc();
        idle(); lk_in = 1; lset = 1;
        cyc();
        check("hit_clock", oclk, 4'b0001);
        check("hit_use", ouse, 4'b0100);
        lset = 0;
        cyc();
        check("hit_other_set_use", ouse, 4'b0000);
        idle(); ev = 1; eset = 1; emask = 4'b0010; ifev = 4'b0110;
        cyc();
        idle(); lk_in = 1; lset = 1;
        cyc();
        check("evict_clock", oclk, 4'b0100);
        check("evict_use", ouse, 4'b0110);
        ev = 1; eset = 3; emask = 4'b1000; ifev = 4'b1000;
        hv = 1; hset = 3; hmask = 4'b0001; lk_in = 1; lset = 3;
        cyc();
        idle();
        check("fwd_lookup_valid", {3'b0, lvo}, 4'b0001);
        check("fwd_clock_wrap", oclk, 4'b0001);
        check("fwd_use_merge", ouse, 4'b1001);
        flush = 1;
        cyc();
        idle();
        check("flush_ready_low", {3'b0, ready}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            lk_in = 1; lset = 1;
            cyc();
            check("flush_ready_low", {3'b0, ready}, 4'b0000);
            check("flush_lookup_ignored", {3'b0, lvo}, 4'b0000);
        end
        idle();
        cyc();
        check("flush_ready_high", {3'b0, ready}, 4'b0001);
        for (int s = 0; s < N; s++) begin
            lk_in = 1; lset = 2'(s);
            cyc();
            check("flush_clock", oclk, 4'b0001);
            check("flush_use", ouse, 4'b0000);
        end
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom % 400) == 0;
            flush = ($urandom % 80) == 0;
            lk_in = $urandom % 2;
            lset  = 2'($urandom);
            hv    = $urandom % 2;
            hset  = 2'($urandom);
            hmask = 4'b0001 << $urandom_range(0, 3);
            ev    = $urandom % 2;
            eset  = 2'($urandom);
            emask = ($urandom % 5 == 0) ? 4'b0000 : 4'b0001 << $urandom_range(0, 3);
            ifev  = 4'($urandom);
            if ($urandom % 4 == 0) eset = hset;
            if ($urandom % 4 == 0) lset = eset;
            cyc();
        end
        rst = 0;
        idle();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
